// File: rtl/mmio_pkg.sv
// Shared address map, status-field layout and reset constants for the DMEM MMIO responder.
package mmio_pkg;

  localparam logic [9:0] GPIO_ADDR       = 10'h3F0;
  localparam logic [9:0] TX_DATA_ADDR    = 10'h3F1;
  localparam logic [9:0] TX_STATUS_ADDR  = 10'h3F2;
  localparam logic [9:0] CYCLE_LO_ADDR   = 10'h3F3;
  localparam logic [9:0] CYCLE_HI_ADDR   = 10'h3F4;
  localparam logic [9:0] TIMER_CMP_ADDR  = 10'h3F5;
  localparam logic [9:0] IRQ_STATUS_ADDR = 10'h3F6;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_CNT_LSB   = 4;
  localparam int STAT_CNT_W     = 5;
  localparam int IRQ_PEND_BIT   = 0;

  localparam logic [31:0] TIMER_CMP_RST = 32'hFFFF_FFFF;

  function automatic logic [31:0] tx_status_word(input logic full, input logic empty,
                                                 input logic ovf,
                                                 input logic [STAT_CNT_W-1:0] cnt);
    logic [31:0] w;
    w = '0;
    w[STAT_FULL_BIT]  = full;
    w[STAT_EMPTY_BIT] = empty;
    w[STAT_OVF_BIT]   = ovf;
    w[STAT_CNT_LSB +: STAT_CNT_W] = cnt;
    return w;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with registered pointers; head reads 0 while empty so the output is defined after reset.
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count,
  output logic [DATA_W-1:0] head
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              pop_ok;
  logic              push_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign pop_ok  = pop && !empty;
  // Fullness is judged before the edge, so a simultaneous pop makes room for the push.
  assign push_ok = push && (!full || pop_ok);
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// DMEM-side responder: word RAM in the low map, GPIO / TX FIFO / cycle timer MMIO at the top.
module dmem_mmio_responder
  import mmio_pkg::*;
#(
  parameter int RAM_WORDS  = 896,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic [9:0]  address_DMEM,
  input  logic [31:0] write_data_DMEM,
  input  logic        MemWrite,
  input  logic        MemRead,
  output logic [31:0] data_DMEM,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [15:0] gpio_out,
  output logic        irq
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]      ram [RAM_WORDS];
  logic             in_ram;
  logic             wr_gpio, wr_txd, wr_stat, wr_cyc_lo, wr_cmp, wr_irq;
  logic             rd_cyc_lo;
  logic [15:0]      gpio_q;
  logic [63:0]      cycle_cnt;
  logic [31:0]      cycle_hi_snap;
  logic [31:0]      timer_cmp;
  logic             irq_pend;
  logic             tx_ovf;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;
  logic             tx_pop;

  assign in_ram    = ({22'b0, address_DMEM} < RAM_WORDS);
  assign wr_gpio   = MemWrite && (address_DMEM == GPIO_ADDR);
  assign wr_txd    = MemWrite && (address_DMEM == TX_DATA_ADDR);
  assign wr_stat   = MemWrite && (address_DMEM == TX_STATUS_ADDR);
  assign wr_cyc_lo = MemWrite && (address_DMEM == CYCLE_LO_ADDR);
  assign wr_cmp    = MemWrite && (address_DMEM == TIMER_CMP_ADDR);
  assign wr_irq    = MemWrite && (address_DMEM == IRQ_STATUS_ADDR);
  assign rd_cyc_lo = MemRead  && (address_DMEM == CYCLE_LO_ADDR);

  assign tx_valid = !fifo_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign gpio_out = gpio_q;
  assign irq      = irq_pend;

  sync_fifo #(
    .DATA_W (8),
    .DEPTH  (FIFO_DEPTH),
    .CNT_W  (CNT_W)
  ) u_tx_fifo (
    .clk       (CLK),
    .rst_n     (RSTn),
    .push      (wr_txd),
    .push_data (write_data_DMEM[7:0]),
    .pop       (tx_pop),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head      (tx_data)
  );

  // RAM contents are deliberately left unreset.
  always_ff @(posedge CLK) begin
    if (MemWrite && in_ram) ram[address_DMEM] <= write_data_DMEM;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      gpio_q    <= '0;
      timer_cmp <= TIMER_CMP_RST;
      tx_ovf    <= 1'b0;
    end else begin
      if (wr_gpio) gpio_q    <= write_data_DMEM[15:0];
      if (wr_cmp)  timer_cmp <= write_data_DMEM;
      if (wr_stat)
        tx_ovf <= 1'b0;
      else if (wr_txd && fifo_full && !tx_pop)
        tx_ovf <= 1'b1;
    end
  end

  // A clearing write beats both the increment and a same-cycle snapshot latch.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cycle_cnt     <= '0;
      cycle_hi_snap <= '0;
      irq_pend      <= 1'b0;
    end else begin
      if (wr_cyc_lo) begin
        cycle_cnt     <= '0;
        cycle_hi_snap <= '0;
      end else begin
        cycle_cnt <= cycle_cnt + 64'd1;
        if (rd_cyc_lo) cycle_hi_snap <= cycle_cnt[63:32];
      end
      if (cycle_cnt[31:0] == timer_cmp)
        irq_pend <= 1'b1;
      else if (wr_irq && write_data_DMEM[IRQ_PEND_BIT])
        irq_pend <= 1'b0;
    end
  end

  always_comb begin
    data_DMEM = '0;
    if (MemRead) begin
      if (in_ram) begin
        data_DMEM = ram[address_DMEM];
      end else begin
        case (address_DMEM)
          GPIO_ADDR:       data_DMEM = {16'b0, gpio_q};
          TX_STATUS_ADDR:  data_DMEM = tx_status_word(fifo_full, fifo_empty, tx_ovf,
                                                      STAT_CNT_W'(fifo_count));
          CYCLE_LO_ADDR:   data_DMEM = cycle_cnt[31:0];
          CYCLE_HI_ADDR:   data_DMEM = cycle_hi_snap;
          TIMER_CMP_ADDR:  data_DMEM = timer_cmp;
          IRQ_STATUS_ADDR: data_DMEM = {31'b0, irq_pend};
          default:         data_DMEM = '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Scoreboard bench for dmem_mmio_responder: load results and TX bytes are queued at drive time and popped on output.
module tb_dmem_mmio_responder;
  import mmio_pkg::*;

  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic [9:0]  address_DMEM = '0;
  logic [31:0] write_data_DMEM = '0;
  logic        MemWrite = 1'b0;
  logic        MemRead = 1'b0;
  logic        tx_ready = 1'b0;
  logic [31:0] data_DMEM;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic [15:0] gpio_out;
  logic        irq;

  int n_checks = 0;
  int n_errors = 0;
  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];

  dmem_mmio_responder dut (
    .CLK             (CLK),
    .RSTn            (RSTn),
    .address_DMEM    (address_DMEM),
    .write_data_DMEM (write_data_DMEM),
    .MemWrite        (MemWrite),
    .MemRead         (MemRead),
    .data_DMEM       (data_DMEM),
    .tx_data         (tx_data),
    .tx_valid        (tx_valid),
    .tx_ready        (tx_ready),
    .gpio_out        (gpio_out),
    .irq             (irq)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic idle();
    @(negedge CLK);
    MemWrite = 1'b0;
    MemRead  = 1'b0;
  endtask

  task automatic wr(input logic [9:0] a, input logic [31:0] d);
    @(negedge CLK);
    address_DMEM    = a;
    write_data_DMEM = d;
    MemWrite        = 1'b1;
    MemRead         = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [9:0] a, input logic [31:0] exp);
    @(negedge CLK);
    address_DMEM = a;
    MemRead      = 1'b1;
    MemWrite     = 1'b0;
    rd_q.push_back(exp);
    #1 check(tag, data_DMEM, rd_q.pop_front());
  endtask

  task automatic rdwr(input string tag, input logic [9:0] a, input logic [31:0] d,
                      input logic [31:0] exp);
    @(negedge CLK);
    address_DMEM    = a;
    write_data_DMEM = d;
    MemRead         = 1'b1;
    MemWrite        = 1'b1;
    rd_q.push_back(exp);
    #1 check(tag, data_DMEM, rd_q.pop_front());
  endtask

  task automatic push_tx(input logic [7:0] b, input bit keep);
    wr(TX_DATA_ADDR, {24'b0, b});
    if (keep) tx_q.push_back(b);
  endtask

  task automatic drain(input string tag, input int exp_cycles);
    int t;
    t = 0;
    @(negedge CLK);
    tx_ready = 1'b1;
    MemWrite = 1'b0;
    MemRead  = 1'b0;
    while ((tx_q.size() != 0 || tx_valid) && t < 64) begin
      @(negedge CLK);
      #3 t++;
    end
    check({tag, "_cycles"}, t, exp_cycles);
    check({tag, "_valid"}, {31'b0, tx_valid}, 32'd0);
    tx_ready = 1'b0;
  endtask

  // Every accepted byte must appear at the head in push order.
  always begin
    @(negedge CLK);
    #2;
    if (RSTn && tx_valid && tx_ready) begin
      if (tx_q.size() == 0) check("tx_extra_byte", 32'(tx_q.size()), 32'd1);
      else                  check("tx_byte", {24'b0, tx_data}, {24'b0, tx_q.pop_front()});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    check("rst_gpio_out", {16'b0, gpio_out}, 32'd0);
    check("rst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("rst_tx_data",  {24'b0, tx_data}, 32'd0);
    check("rst_irq",      {31'b0, irq}, 32'd0);
    check("rst_data",     data_DMEM, 32'd0);
    @(negedge CLK);
    RSTn = 1'b1;

    rd("rst_rd_gpio",   GPIO_ADDR, 32'd0);
    rd("rst_rd_status", TX_STATUS_ADDR, 32'h2);
    rd("rst_rd_cyc_hi", CYCLE_HI_ADDR, 32'd0);
    rd("rst_rd_cmp",    TIMER_CMP_ADDR, 32'hFFFF_FFFF);

    wr(10'd5, 32'hDEAD_BEEF);
    rd("ram_w5", 10'd5, 32'hDEAD_BEEF);
    wr(10'd895, 32'h0BAD_F00D);
    rd("ram_top", 10'd895, 32'h0BAD_F00D);
    rd("ram_w5_again", 10'd5, 32'hDEAD_BEEF);
    wr(10'h3E0, 32'h1234_5678);
    rd("gap_rd", 10'h3E0, 32'd0);
    wr(10'h3FF, 32'hFFFF_FFFF);
    rd("unmapped_rd", 10'h3FF, 32'd0);
    rd("txdata_rd", TX_DATA_ADDR, 32'd0);

    wr(GPIO_ADDR, 32'h1234_ABCD);
    rd("gpio_rd", GPIO_ADDR, 32'h0000_ABCD);
    idle();
    #1;
    check("gpio_out", {16'b0, gpio_out}, 32'h0000_ABCD);
    check("no_memread_zero", data_DMEM, 32'd0);
    rdwr("rdwr_prewrite", GPIO_ADDR, 32'h0000_5555, 32'h0000_ABCD);
    rd("rdwr_after", GPIO_ADDR, 32'h0000_5555);

    for (int i = 0; i < 9; i++) push_tx(8'h41 + 8'(i), i < 8);
    rd("tx_status_ovf", TX_STATUS_ADDR, 32'h85);
    drain("drain1", 8);
    rd("tx_status_sticky", TX_STATUS_ADDR, 32'h6);
    wr(TX_STATUS_ADDR, 32'd0);
    rd("tx_status_clr", TX_STATUS_ADDR, 32'h2);

    for (int i = 0; i < 8; i++) push_tx(8'h60 + 8'(i), 1'b1);
    rd("tx_status_full", TX_STATUS_ADDR, 32'h81);
    @(negedge CLK);
    tx_ready        = 1'b1;
    address_DMEM    = TX_DATA_ADDR;
    write_data_DMEM = 32'h50;
    MemWrite        = 1'b1;
    MemRead         = 1'b0;
    tx_q.push_back(8'h50);
    @(negedge CLK);
    tx_ready     = 1'b0;
    MemWrite     = 1'b0;
    MemRead      = 1'b1;
    address_DMEM = TX_STATUS_ADDR;
    rd_q.push_back(32'h81);
    #1 check("tx_full_pushpop", data_DMEM, rd_q.pop_front());
    drain("drain2", 8);

    wr(TIMER_CMP_ADDR, 32'd20);
    wr(CYCLE_LO_ADDR, 32'd0);
    idle();
    for (int n = 1; n <= 22; n++) begin
      @(negedge CLK);
      #1 check($sformatf("irq_c%0d", n), {31'b0, irq}, {31'b0, n >= 21});
    end
    rd("irq_status_rd", IRQ_STATUS_ADDR, 32'd1);
    wr(IRQ_STATUS_ADDR, 32'd0);
    idle();
    #1 check("irq_w0_keeps", {31'b0, irq}, 32'd1);
    wr(IRQ_STATUS_ADDR, 32'd1);
    idle();
    #1 check("irq_w1c", {31'b0, irq}, 32'd0);

    wr(CYCLE_LO_ADDR, 32'd0);
    idle();
    repeat (9) @(negedge CLK);
    rd("cycle_lo_10", CYCLE_LO_ADDR, 32'd10);
    rd("cycle_hi_0", CYCLE_HI_ADDR, 32'd0);

    for (int i = 0; i < 4; i++) push_tx(8'hA0 + 8'(i), 1'b1);
    wr(GPIO_ADDR, 32'h77);
    idle();
    #1 check("gpio_pre_rst", {16'b0, gpio_out}, 32'h77);
    @(negedge CLK);
    tx_ready = 1'b1;
    @(negedge CLK);
    #3 RSTn = 1'b0;
    #1;
    check("midrst_tx_valid", {31'b0, tx_valid}, 32'd0);
    check("midrst_gpio",     {16'b0, gpio_out}, 32'd0);
    check("midrst_tx_data",  {24'b0, tx_data}, 32'd0);
    check("midrst_irq",      {31'b0, irq}, 32'd0);
    tx_q.delete();
    tx_ready = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    rd("post_rst_status", TX_STATUS_ADDR, 32'h2);
    rd("post_rst_cmp", TIMER_CMP_ADDR, 32'hFFFF_FFFF);
    rd("post_rst_cyc_hi", CYCLE_HI_ADDR, 32'd0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_mmio_responder.md
# dmem_mmio_responder

Data-side responder for the single-cycle core's DMEM port. Serves full-word loads and stores on the 10-bit word address from the core. Low addresses go to a RAM. The top of the map holds memory-mapped I/O:
- a GPIO register,
- a byte TX FIFO with a valid/ready output,
- a 64-bit cycle counter with compare interrupt.

Reads are combinational, matching the core's single-cycle load path. All state changes occur on the rising edge of `CLK`.

## Interface
Parameters:
- `RAM_WORDS`, default 896: RAM depth in words, occupying word addresses 0..RAM_WORDS-1. Must be ≤ 1008.
- `FIFO_DEPTH`, default 8: TX FIFO entries. Must be a power of 2, ≤ 16.

Ports (one clock; reset is asynchronous and active-low):
- `CLK` input 1: clock, rising edge.
- `RSTn` input 1: asynchronous active-low reset.
- `address_DMEM` input 10: word address from the core.
- `write_data_DMEM` input 32: store data.
- `MemWrite` input 1: store strobe, one cycle per store.
- `MemRead` input 1: load qualifier.
- `data_DMEM` output 32: load data, combinational.
- `tx_data` output 8: FIFO head byte.
- `tx_valid` output 1: FIFO non-empty.
- `tx_ready` input 1: consumer accepts the head byte this cycle.
- `gpio_out` output 16: GPIO register.
- `irq` output 1: timer interrupt pending, level.

## Operation
Address map (word addresses):
- 0..RAM_WORDS-1: RAM, read/write.
- 0x3F0 GPIO: read/write bits[15:0]; upper bits read 0.
- 0x3F1 TX_DATA: write pushes bits[7:0]; reads 0.
- 0x3F2 TX_STATUS: read fields are bit0 full, bit1 empty, bit2 overflow (sticky), bits[8:4] count. Any write clears overflow.
- 0x3F3 CYCLE_LO: read returns counter[31:0] and latches counter[63:32] into the HI snapshot at the edge. Any write clears the whole 64-bit counter and the snapshot.
- 0x3F4 CYCLE_HI: read returns the snapshot; writes are ignored.
- 0x3F5 TIMER_CMP: read/write.
- 0x3F6 IRQ_STATUS: bit0 is pending. Writing 1 to bit0 clears it; writing 0 has no effect.
- Any other address, including the RAM gap up to 0x3EF: reads 0, writes ignored, no error.

Access rules:
- `data_DMEM` is 0 when `MemRead`=0.
- All accesses are full-word; byte offsets are already dropped by the core.
- `MemRead` and `MemWrite` both high: the write commits at the edge, and `data_DMEM` shows the pre-write value.

Counter:
- Increments every cycle, wraps 2^64-1 → 0.
- A clearing write has priority over the increment; the value after that edge is 0.

Interrupt:
- At each edge where counter[31:0] == TIMER_CMP, pending is set.
- Set has priority over a simultaneous W1C clear.
- `irq` = pending.

FIFO:
- `tx_valid` = !empty; `tx_data` = head.
- Pop occurs at an edge with `tx_valid` && `tx_ready`.
- Push occurs on a TX_DATA write.
- Full is evaluated before the edge. Push while full with no pop: byte dropped, overflow set.
- Push while full with a simultaneous pop: both occur, count unchanged.
- Push while empty: byte appears at head the next cycle; there is no fall-through.
- Pointers wrap modulo FIFO_DEPTH.

## Timing
- Load latency: 0 cycles (combinational). Stores are visible to reads in the cycle after the edge.
- `tx_valid` rises in the cycle after the first push. It falls in the cycle after the pop that empties the FIFO.
- `irq` rises one cycle after the matching counter value is present.
- Reset values:
  - `gpio_out`=0, `tx_valid`=0, `tx_data`=0, `irq`=0.
  - counter=0, snapshot=0, TIMER_CMP=0xFFFFFFFF.
  - FIFO empty, overflow=0, `data_DMEM`=0.
  - RAM contents are not reset (undefined until written).
- Reset asserted mid-operation: all MMIO state returns to reset values asynchronously, and any in-flight FIFO bytes are discarded.

## Structure
- Package `mmio_pkg`: address constants GPIO_ADDR=10'h3F0, TX_DATA_ADDR, TX_STATUS_ADDR, CYCLE_LO_ADDR, CYCLE_HI_ADDR, TIMER_CMP_ADDR, IRQ_STATUS_ADDR; status bit indices; TIMER_CMP reset value.
- Sub-module `sync_fifo`, parameterised by width and depth. Ports: push/pop/full/empty/count/head.
- Address decode, RAM, counter, and registers live in the top level.

## Test plan
- Reset, then read GPIO, TX_STATUS, CYCLE_HI → 0, 0x2 (empty), 0; `irq`=0, `tx_valid`=0.
- Write 0xDEADBEEF to word 5, read word 5 → 0xDEADBEEF. Write to 0x3E0, read 0x3E0 → 0.
- With `tx_ready`=0, push 9 bytes 0x41..0x49 (depth 8) → TX_STATUS = full, overflow, count 8. Raise `tx_ready` → bytes 0x41..0x48 drain in order, one per cycle, then `tx_valid`=0.
- FIFO full with `tx_ready`=1 during a push of 0x50 → count stays 8, 0x50 is delivered last.
- Write TIMER_CMP=20, clear counter → `irq`=1 at 21 cycles after the clear edge. W1C to IRQ_STATUS → `irq`=0.
- Clear counter, wait 10 cycles, read CYCLE_LO → 10 (±core sampling edge), then CYCLE_HI → 0. Assert `RSTn` low mid-drain → `tx_valid`=0 immediately, `gpio_out`=0.
